mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers; successor to the combinational ALU.
- Sits in the EX stage beside the ALU.
- Accepts one operation per start pulse and holds busy for a programmable latency.
- Commits the result to HI/LO when the latency expires; the hazard unit stalls dependent instructions on busy.

Parameters:
WIDTH, 32, operand and HI/LO width.
MULT_CYCLES, 5, busy cycles for mult-class ops (>=1).
DIV_CYCLES, 10, busy cycles for div-class ops (>=1).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  launch MDUOp this cycle; single-cycle pulse.
MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7-10 madd/maddu/msub/msubu (optional feature).
A  input  WIDTH  rs operand / dividend.
B  input  WIDTH  rt operand / divisor.
busy  output  1  operation in flight.
HI  output  WIDTH  architectural HI (registered).
LO  output  WIDTH  architectural LO (registered).

Behaviour:
- Reset (asynchronous, reset_n low): HI=0, LO=0, busy=0, counter=0, pending result cleared. Reset mid-operation abandons the op; HI/LO stay 0.
- States: IDLE, RUN.
- IDLE + start + mult-class op:
  - Compute the 2*WIDTH result into a pending register; load counter=MULT_CYCLES; busy=1 from the next cycle.
  - Div-class ops are identical but load DIV_CYCLES.
- RUN: counter decrements each cycle. On the edge where counter==1, {HI,LO}<=pending, busy->0, state->IDLE.
  - Start at cycle 0 therefore gives busy high for exactly N cycles (cycles 1..N); new HI/LO are visible in cycle N+1 together with busy=0.
- mthi/mtlo with start in IDLE: HI<=A (resp. LO<=A) at that edge; busy stays 0.
- start in RUN (any op) is ignored entirely; the pipeline guarantees this does not happen, and the bench checks that it is dropped.
- start with MDUOp=0 or an undefined code: no effect.
- mult: signed A*B; multu: unsigned. HI=upper WIDTH bits, LO=lower WIDTH bits.
- div: signed division, quotient truncated toward zero, LO=quotient, HI=remainder; the remainder takes the sign of the dividend.
- divu: unsigned division, same LO/HI assignment.
- Divide by zero (div or divu): LO=all ones, HI=A. Still takes DIV_CYCLES.
- Signed overflow (A=most negative, B=-1): LO=A, HI=0.
- HI/LO read ports are the registers themselves; no bypass of the pending result.
- Operands are sampled only in the start cycle; later changes on A/B are ignored.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 7-10 are valid, MULT_CYCLES latency each.
  - madd: {HI,LO} += signed A*B.
  - maddu: {HI,LO} += unsigned A*B.
  - msub: {HI,LO} -= signed A*B.
  - msubu: {HI,LO} -= unsigned A*B.
  - All are 2*WIDTH arithmetic mod 2^(2*WIDTH).
  - The accumulator base is the HI/LO value at the start cycle.
- Not defined: codes 7-10 are treated as undefined (no effect, busy stays 0).

Test Plan:
- Reset then mult, A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat as multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div, A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- divu, A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234. div, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0xAAAA5555 then mtlo A=0x1 on consecutive cycles -> HI/LO update at each edge, busy never asserts. Then a start of mult during a running div -> ignored; the div result commits unchanged.
- Assert reset_n low in the 3rd busy cycle of div -> busy, HI and LO go to 0 immediately (asynchronously); after release, no late commit occurs.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then madd A=1, B=1 -> HI=1, LO=0; msub A=1, B=2 -> HI=0, LO=0xFFFFFFFE. Without the macro, the same ops leave HI/LO unchanged and busy=0.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2*WIDTH-1:0] pending, pending_n;
  logic [WIDTH-1:0]   hi_n, lo_n;
  mdu_op_e            op;

  assign op   = mdu_op_e'(MDUOp);
  assign busy = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Multiplier: operands widened to 2*WIDTH so one product serves both signednesses
  // ---------------------------------------------------------------------------
  logic               mul_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;

`ifdef MDU_MADD_EN
  assign mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
`else
  assign mul_signed = (op == OP_MULT);
`endif

  assign a_ext   = mul_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
  assign b_ext   = mul_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
  assign product = a_ext * b_ext;

  // ---------------------------------------------------------------------------
  // Divider: divide magnitudes unsigned, then restore signs. The most-negative / -1
  // case falls out naturally (quotient magnitude 2^(WIDTH-1) wraps back to A, rem 0).
  // ---------------------------------------------------------------------------
  logic               div_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [2*WIDTH-1:0] div_result;

  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & A[WIDTH-1];
  assign b_neg      = div_signed & B[WIDTH-1];
  assign a_mag      = a_neg ? (WIDTH'(0) - A) : A;
  assign b_mag      = b_neg ? (WIDTH'(0) - B) : B;
  assign b_safe     = (b_mag == WIDTH'(0)) ? WIDTH'(1) : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
  assign rem        = a_neg ? (WIDTH'(0) - r_mag) : r_mag;
  assign div_result = (B == WIDTH'(0)) ? {A, {WIDTH{1'b1}}} : {rem, quot};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n   = state;
    cnt_n     = cnt;
    pending_n = pending;
    hi_n      = HI;
    lo_n      = LO;

    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pending_n = product;
              cnt_n     = MULT_LOAD;
              state_n   = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              pending_n = div_result;
              cnt_n     = DIV_LOAD;
              state_n   = ST_RUN;
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              pending_n = {HI, LO} + product;
              cnt_n     = MULT_LOAD;
              state_n   = ST_RUN;
            end
            OP_MSUB, OP_MSUBU: begin
              pending_n = {HI, LO} - product;
              cnt_n     = MULT_LOAD;
              state_n   = ST_RUN;
            end
`endif
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        // Any start while running is dropped; only the countdown matters here.
        if (cnt == CNT_W'(1)) begin
          {hi_n, lo_n} = pending;
          cnt_n        = '0;
          state_n      = ST_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the pending result is reset too, so an abandoned op can never leak into HI/LO.
      state   <= ST_IDLE;
      cnt     <= '0;
      pending <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      HI      <= hi_n;
      LO      <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed cases plus randomized ops checked against
// a 64-bit arithmetic reference model; the monitor pops expectations on DUT commits.
module tb_mdu_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [3:0]   MDUOp;
  logic [W-1:0] A, B;
  logic         busy;
  logic [W-1:0] HI, LO;

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output exp_t e);
    longint      sa, sb, q, r;
    logic [63:0] acc, prod_s, prod_u;
    sa     = $signed(a);
    sb     = $signed(b);
    prod_s = sa * sb;
    prod_u = {32'b0, a} * {32'b0, b};
    acc    = {model_hi, model_lo};
    e.cycles = 0;
    case (op)
      4'd1: begin acc = prod_s; e.cycles = MC; end
      4'd2: begin acc = prod_u; e.cycles = MC; end
      4'd3: begin
        e.cycles = DC;
        if (b == 0) acc = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          acc = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        e.cycles = DC;
        if (b == 0) acc = {a, 32'hFFFF_FFFF};
        else        acc = {a % b, a / b};
      end
      4'd5: acc[63:32] = a;
      4'd6: acc[31:0]  = a;
`ifdef MDU_MADD_EN
      4'd7:  begin acc = acc + prod_s; e.cycles = MC; end
      4'd8:  begin acc = acc + prod_u; e.cycles = MC; end
      4'd9:  begin acc = acc - prod_s; e.cycles = MC; end
      4'd10: begin acc = acc - prod_u; e.cycles = MC; end
`endif
      default: ;
    endcase
    model_hi = acc[63:32];
    model_lo = acc[31:0];
    e.hi     = model_hi;
    e.lo     = model_lo;
  endtask

  // Called at posedge+1. Drives one start pulse, then scrambles inputs and waits for idle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject);
    exp_t e;
    int   n;
    model_apply(op, a, b, e);
    sb_q.push_back(e);
    start = 1'b1;
    MDUOp = op;
    A     = a;
    B     = b;
    @(posedge clk); #1;
    start = 1'b0;
    MDUOp = 4'($urandom_range(0, 10));
    A     = $urandom;
    B     = $urandom;
    n     = 0;
    while (busy && n < 60) begin
      if (inject && n == 2) begin
        start = 1'b1;
        MDUOp = 4'($urandom_range(1, 6));
        A     = $urandom;
        B     = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (busy) check("busy_timeout", 64'(busy), 64'(0));
  endtask

  // Monitor: compares on commit (busy falling) or one cycle after an immediate op.
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;
  bit   chk_imm   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
      chk_imm   = 1'b0;
    end else begin
      if (chk_imm) begin
        e = sb_q.pop_front();
        check("imm_hi", 64'(HI), 64'(e.hi));
        check("imm_lo", 64'(LO), 64'(e.lo));
        check("imm_busy", 64'(busy), 64'(0));
        chk_imm = 1'b0;
      end
      if (busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          check("unexpected_commit", 64'(sb_q.size()), 64'(1));
        end else begin
          e = sb_q.pop_front();
          check("commit_hi", 64'(HI), 64'(e.hi));
          check("commit_lo", 64'(LO), 64'(e.lo));
          check("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
        end
        busy_cnt = 0;
      end
      if (start && !busy && sb_q.size() > 0)
        if (sb_q[0].cycles == 0) chk_imm = 1'b1;
      prev_busy = busy;
    end
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    start   = 1'b0;
    MDUOp   = '0;
    A       = '0;
    B       = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_hi", 64'(HI), 64'(0));
    check("reset_lo", 64'(LO), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(4'd4, 32'h0000_1234, 32'd0, 1'b0);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(4'd3, 32'hFFFF_0005, 32'd0, 1'b0);
    issue(4'd5, 32'hAAAA_5555, 32'd0, 1'b0);
    issue(4'd6, 32'h0000_0001, 32'd0, 1'b0);
    issue(4'd0, 32'h1111_2222, 32'd3, 1'b0);
    issue(4'd3, 32'd1000, 32'hFFFF_FFF9, 1'b1);

    // Reset in the third busy cycle of a div: abandon it, no late commit
    start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_hi", 64'(HI), 64'(0));
    check("midrst_lo", 64'(LO), 64'(0));
    @(posedge clk); #1;
    reset_n  = 1'b1;
    model_hi = '0;
    model_lo = '0;
    repeat (15) @(posedge clk);
    #1;
    check("postrst_busy", 64'(busy), 64'(0));
    check("postrst_hi", 64'(HI), 64'(0));
    check("postrst_lo", 64'(LO), 64'(0));

    // Accumulate ops (no effect unless the feature is built in)
    issue(4'd5, 32'h0000_0000, 32'd0, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(4'd7, 32'd1, 32'd1, 1'b0);
    issue(4'd9, 32'd1, 32'd2, 1'b0);
    issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(4'd10, 32'h0000_0003, 32'h8000_0000, 1'b0);

    // Randomized ops including undefined codes and divide corner cases
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 12));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, ra, rb, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
